// File: rtl/macguffin_pkg.sv
// Shared types for the MacGuffin core arbiter: block width, block type and arbiter states.
package macguffin_pkg;

  localparam int unsigned BLOCK_W = 64;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDeliver
  } arb_state_e;

  // Index increment modulo n, for non-power-of-two channel counts.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping around.
module rr_pick #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         req_i,
  input  logic [$clog2(N_CH)-1:0] ptr_i,
  output logic [$clog2(N_CH)-1:0] gnt_idx_o,
  output logic                    any_req_o
);

  localparam int unsigned IdxW = $clog2(N_CH);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N_CH);
      if (!any_req_o && req_i[cand]) begin
        gnt_idx_o = cand;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/macguffin_arbiter.sv
// Round-robin sharing of one non-pipelined MacGuffin core between N_CH AXI-Stream requesters;
// one block in flight, result returned to the channel that supplied it.
module macguffin_arbiter
  import macguffin_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0][BLOCK_W-1:0]  s_axis_tdata,
  input  logic [N_CH-1:0]               s_axis_tvalid,
  output logic [N_CH-1:0]               s_axis_tready,
  output logic [N_CH-1:0][BLOCK_W-1:0]  m_axis_tdata,
  output logic [N_CH-1:0]               m_axis_tvalid,
  input  logic [N_CH-1:0]               m_axis_tready,
  output logic [BLOCK_W-1:0]            core_m_tdata,
  output logic                          core_m_tvalid,
  input  logic                          core_m_tready,
  input  logic [BLOCK_W-1:0]            core_s_tdata,
  input  logic                          core_s_tvalid,
  output logic                          core_s_tready,
  output logic                          busy,
  output logic [$clog2(N_CH)-1:0]       owner
);

  localparam int unsigned IdxW = $clog2(N_CH);

  if (N_CH < 2 || N_CH > 8) begin : g_bad_param
    $error("macguffin_arbiter: N_CH must be in 2..8");
  end

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  block_t          blk_q, blk_d;
  block_t          res_q, res_d;

  logic [IdxW-1:0] gnt_idx;
  logic            any_req;

  rr_pick #(
    .N_CH (N_CH)
  ) u_rr_pick (
    .req_i     (s_axis_tvalid),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    blk_d         = blk_q;
    res_d         = res_q;
    s_axis_tready = '0;
    m_axis_tvalid = '0;
    m_axis_tdata  = '0;
    core_m_tvalid = 1'b0;
    core_m_tdata  = '0;
    core_s_tready = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ready is withheld while reset is asserted so no block is accepted and then dropped.
        if (any_req && !rst) begin
          s_axis_tready[gnt_idx] = 1'b1;
          blk_d                  = s_axis_tdata[gnt_idx];
          owner_d                = gnt_idx;
          state_d                = StIssue;
        end
      end
      StIssue: begin
        core_m_tvalid = 1'b1;
        core_m_tdata  = blk_q;
        if (core_m_tready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        core_s_tready = 1'b1;
        if (core_s_tvalid) begin
          res_d   = core_s_tdata;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        m_axis_tvalid[owner_q] = 1'b1;
        m_axis_tdata[owner_q]  = res_q;
        if (m_axis_tready[owner_q]) begin
          rr_ptr_d = IdxW'(wrap_inc(32'(owner_q), N_CH));
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      blk_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      blk_q    <= blk_d;
      res_q    <= res_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign owner = owner_q;

endmodule

// File: tb/tb_macguffin_arbiter.sv
// Bench for macguffin_arbiter: stand-in core with key-schedule stall, per-channel request queues
// and a round-robin order model.
module tb_macguffin_arbiter;
  import macguffin_pkg::*;

  localparam int NCh     = 4;
  localparam int CoreLat = 5;   // core input handshake to result handshake, in cycles
  localparam int KeyCyc  = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCh-1:0][63:0] s_axis_tdata;
  logic [NCh-1:0]       s_axis_tvalid;
  logic [NCh-1:0]       s_axis_tready;
  logic [NCh-1:0][63:0] m_axis_tdata;
  logic [NCh-1:0]       m_axis_tvalid;
  logic [NCh-1:0]       m_axis_tready;
  logic [63:0]          core_m_tdata;
  logic                 core_m_tvalid;
  logic                 core_m_tready;
  logic [63:0]          core_s_tdata;
  logic                 core_s_tvalid;
  logic                 core_s_tready;
  logic                 busy;
  logic [1:0]           owner;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [63:0] pend [NCh][64];
  int          head [NCh];
  int          tail [NCh];
  int          rr_m  = 0;

  macguffin_arbiter #(
    .N_CH (NCh)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .core_m_tdata  (core_m_tdata),
    .core_m_tvalid (core_m_tvalid),
    .core_m_tready (core_m_tready),
    .core_s_tdata  (core_s_tdata),
    .core_s_tvalid (core_s_tvalid),
    .core_s_tready (core_s_tready),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] core_fn(input logic [63:0] x);
    return {x[50:0], x[63:51]} ^ 64'hA5A5_5A5A_C3C3_3C3C;
  endfunction

  // Stand-in cipher core: key schedule after reset, then one block at a time.
  int          key_cnt, lat_cnt;
  logic        cbusy, cvalid;
  logic [63:0] cres;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      key_cnt <= KeyCyc;
      lat_cnt <= 0;
      cbusy   <= 1'b0;
      cvalid  <= 1'b0;
      cres    <= '0;
    end else begin
      if (key_cnt != 0) key_cnt <= key_cnt - 1;
      if (core_m_tvalid && core_m_tready) begin
        cbusy   <= 1'b1;
        lat_cnt <= CoreLat - 2;
        cres    <= core_fn(core_m_tdata);
      end else if (cbusy && !cvalid) begin
        if (lat_cnt == 0) cvalid <= 1'b1;
        else lat_cnt <= lat_cnt - 1;
      end
      if (cvalid && core_s_tready) begin
        cvalid <= 1'b0;
        cbusy  <= 1'b0;
      end
    end
  end
  assign core_m_tready = (key_cnt == 0) && !cbusy && !rst;
  assign core_s_tvalid = cvalid;
  assign core_s_tdata  = cres;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NCh-1:0] oh(input int c);
    logic [NCh-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int model_next();
    for (int i = 0; i < NCh; i++) begin
      int c;
      c = (rr_m + i) % NCh;
      if (head[c] < tail[c]) return c;
    end
    return 0;
  endfunction

  task automatic enq(input int c, input logic [63:0] v);
    pend[c][tail[c]] = v;
    tail[c]++;
  endtask

  task automatic drive();
    for (int c = 0; c < NCh; c++) begin
      s_axis_tvalid[c] = (head[c] < tail[c]);
      s_axis_tdata[c]  = (head[c] < tail[c]) ? pend[c][head[c]] : 64'h0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One full transaction for the channel the model says is next; bp = cycles of owner back-pressure.
  task automatic serve_one(input string tag, input int bp, output int gcyc);
    int                   ch, t;
    logic [63:0]          blk, res;
    logic [NCh-1:0][63:0] exp_data;
    ch  = model_next();
    blk = pend[ch][head[ch]];
    res = core_fn(blk);
    m_axis_tready = (bp > 0) ? ~oh(ch) : '1;
    #1;
    t = 0;
    while (s_axis_tready == '0 && t < 300) begin step(); t++; end
    check({tag, " grant"}, s_axis_tready, oh(ch));
    gcyc = cyc;
    step();
    head[ch]++;
    drive();
    check({tag, " issue"}, {core_m_tvalid, core_m_tdata, busy, owner}, {1'b1, blk, 1'b1, 2'(ch)});
    t = 0;
    while (!core_m_tready && t < 300) begin
      check({tag, " stall hold"}, {core_m_tvalid, core_m_tdata}, {1'b1, blk});
      step();
      t++;
    end
    t = 0;
    while (m_axis_tvalid == '0 && t < 300) begin step(); t++; end
    exp_data     = '0;
    exp_data[ch] = res;
    check({tag, " result"}, {m_axis_tvalid, m_axis_tdata}, {oh(ch), exp_data});
    for (int i = 0; i < bp; i++) begin
      step();
      check({tag, " bp hold"}, {busy, s_axis_tready, m_axis_tvalid, m_axis_tdata},
            {1'b1, {NCh{1'b0}}, oh(ch), exp_data});
    end
    m_axis_tready = '1;
    step();
    check({tag, " idle"}, {busy, m_axis_tvalid}, {1'b0, {NCh{1'b0}}});
    rr_m = (ch + 1) % NCh;
  endtask

  initial begin
    int g0, g1, t, mask, n;
    for (int c = 0; c < NCh; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
    rst           = 1'b1;
    m_axis_tready = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;

    // Reset values, with all four channels already requesting.
    enq(0, 64'h1111_1111_1111_1111);
    enq(1, 64'h2222_2222_2222_2222);
    enq(2, 64'h3333_3333_3333_3333);
    enq(3, 64'h4444_4444_4444_4444);
    drive();
    step();
    step();
    check("reset outputs",
          {busy, owner, s_axis_tready, m_axis_tvalid, m_axis_tdata, core_m_tvalid, core_m_tdata,
           core_s_tready}, '0);

    // Simultaneous requests from reset: strict rotation 0,1,2,3 through the key-schedule stall.
    rst = 1'b0;
    serve_one("all4 ch0", 0, g0);
    serve_one("all4 ch1", 0, g0);
    serve_one("all4 ch2", 0, g0);
    serve_one("all4 ch3", 0, g0);

    // Single channel, back-to-back blocks: grant-to-grant period is core latency + 3.
    enq(2, 64'h0123_4567_89AB_CDEF);
    enq(2, {$urandom, $urandom});
    drive();
    serve_one("ch2 first", 0, g0);
    serve_one("ch2 second", 0, g1);
    check("ch2 period", 512'(g1 - g0), 512'(CoreLat + 3));

    // Pointer rotation: after ch1, ch3 then ch0.
    enq(1, {$urandom, $urandom});
    drive();
    serve_one("rot ch1", 0, g0);
    enq(0, {$urandom, $urandom});
    enq(3, {$urandom, $urandom});
    drive();
    serve_one("rot ch3", 0, g0);
    serve_one("rot ch0", 0, g0);

    // Owner back-pressure for 20 cycles.
    enq(1, {$urandom, $urandom});
    drive();
    serve_one("bp ch1", 20, g0);

    // Random request subsets and short back-pressure.
    for (int r = 0; r < 25; r++) begin
      mask = $urandom_range(1, (1 << NCh) - 1);
      n    = 0;
      for (int c = 0; c < NCh; c++) begin
        if (mask[c]) begin
          enq(c, {$urandom, $urandom});
          n++;
        end
      end
      drive();
      for (int k = 0; k < n; k++) serve_one("rand", $urandom_range(0, 3), g0);
    end

    // Reset while waiting on the core: the block is dropped and ch0 wins next.
    enq(2, {$urandom, $urandom});
    drive();
    m_axis_tready = '1;
    #1;
    t = 0;
    while (s_axis_tready == '0 && t < 300) begin step(); t++; end
    check("rstwait grant", s_axis_tready, oh(model_next()));
    step();
    head[2]++;
    enq(3, {$urandom, $urandom});
    enq(0, {$urandom, $urandom});
    drive();
    t = 0;
    while (!core_s_tready && t < 300) begin step(); t++; end
    check("rstwait in wait", {core_s_tready, busy, owner}, {2'b11, 2'd2});
    rst = 1'b1;
    #1;
    check("rstwait async clear",
          {busy, owner, s_axis_tready, m_axis_tvalid, m_axis_tdata, core_m_tvalid, core_m_tdata,
           core_s_tready}, '0);
    step();
    step();
    rst  = 1'b0;
    rr_m = 0;
    check("rstwait no result", m_axis_tvalid, '0);
    serve_one("post-rst ch0", 0, g0);
    serve_one("post-rst ch3", 0, g0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/macguffin_arbiter.md
# macguffin_arbiter

Round-robin scheduler that shares one MacGuffin block-cipher core between N_CH independent AXI-Stream requesters. It accepts one 64-bit block from the granted channel and forwards it to the core. It then waits for the core result and returns the ciphertext to the same channel before granting again. It sits between the requester streams and the core's s_axis/m_axis ports. Key loading stays on the core.

## Interface
Parameters:
- N_CH, 4, number of requester channels (2..8)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  [N_CH-1:0][63:0]  plaintext per channel
- s_axis_tvalid  in  N_CH  per-channel block valid
- s_axis_tready  out  N_CH  per-channel accept
- m_axis_tdata  out  [N_CH-1:0][63:0]  ciphertext per channel
- m_axis_tvalid  out  N_CH  per-channel result valid
- m_axis_tready  in  N_CH  per-channel result accept
- core_m_tdata  out  64  block to core s_axis_tdata
- core_m_tvalid  out  1  to core s_axis_tvalid
- core_m_tready  in  1  from core s_axis_tready; low during key schedule
- core_s_tdata  in  64  from core m_axis_tdata
- core_s_tvalid  in  1  from core m_axis_tvalid
- core_s_tready  out  1  to core m_axis_tready
- busy  out  1  high in any state except IDLE
- owner  out  $clog2(N_CH)  channel currently being served

## Operation
- FSM with four states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If any s_axis_tvalid is high, grant the first asserted channel searching from rr_ptr upward, wrapping around.
  - s_axis_tready[grant] = 1 in that same cycle (combinational from tvalid). All other channels see 0.
  - On the handshake, latch the data into blk_q, latch the grant into owner, and go to ISSUE.
- ISSUE: core_m_tvalid = 1 and core_m_tdata = blk_q. On core_m_tready, go to WAIT.
- WAIT: core_s_tready = 1. On core_s_tvalid, latch core_s_tdata into res_q and go to DELIVER.
- DELIVER:
  - m_axis_tvalid[owner] = 1, and m_axis_tdata[owner] = res_q.
  - m_axis_tdata of the other channels is 0.
  - On m_axis_tready[owner], set rr_ptr = owner+1 (mod N_CH) and go to IDLE.
- Only one block is outstanding at any time. The core is treated as non-pipelined.
- A channel that is not granted keeps its valid held, per AXI rules. It waits without penalty.
- Valid is never deasserted by the arbiter once raised. All data is held stable until the handshake.
- A core result that arrives outside WAIT is not accepted: core_s_tready is 0, and the core holds the result.
- Once in DELIVER, back-pressure on the owner channel stalls the arbiter indefinitely. No timeout.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, owner = 0, blk_q = 0, res_q = 0. All tvalid/tready outputs = 0, busy = 0, all tdata = 0.
- A reset mid-operation discards the in-flight block. The core is reset by the same rst.
- Grant handshake at cycle T0; core_m_tvalid rises at T0+1.
- Core result handshake at Tr; m_axis_tvalid[owner] rises at Tr+1.
- After the DELIVER handshake at Td, the state is IDLE at Td+1. The earliest next grant is Td+1.
- Overhead beyond the core: 3 cycles per block with zero back-pressure.
- Simultaneous requests on all channels are served strictly in rotation: rr_ptr, rr_ptr+1, ...
- While the core is in its key schedule after reset, core_m_tready = 0 and the arbiter sits in ISSUE.

## Structure
- macguffin_pkg holds:
  - BLOCK_W = 64
  - the typedef enum for the arbiter state {IDLE, ISSUE, WAIT, DELIVER}
  - a block_t typedef (logic [BLOCK_W-1:0])
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N_CH] and ptr.
  - Outputs: gnt_idx and any_req.
- Top level: FSM, data registers, and output muxing.

## Test plan
- Single channel, ch2 sends 0x0123456789ABCDEF after the key schedule completes:
  - core_m_tdata equals this value one cycle after the grant.
  - m_axis_tvalid[2] carries the core result (checked against the C model).
  - Total latency equals core latency + 3.
- All four channels valid simultaneously from reset, with blocks 0x1111…, 0x2222…, 0x3333…, 0x4444…:
  - Grant order is ch0, ch1, ch2, ch3.
  - Each result appears only on its own channel.
- Pointer rotation: ch1 served, then ch0 and ch3 both valid:
  - ch3 is granted first (rr_ptr = 2), then ch0.
- Back-pressure: m_axis_tready[1] held low for 20 cycles in DELIVER:
  - m_axis_tvalid[1] and the data stay stable.
  - s_axis_tready stays 0 on all channels.
  - busy = 1 throughout.
- Reset asserted in WAIT:
  - All outputs return to their reset values within the same cycle (asynchronously).
  - No m_axis_tvalid is emitted for the dropped block.
  - The next request is granted to ch0.
- Key-schedule stall: ch0 valid immediately after reset:
  - Grant occurs.
  - core_m_tvalid stays high until core_m_tready rises.
  - No data is lost.
